// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: two-flop synchroniser, stable-count qualification,
// registered press/release pulses and a once-per-press long-hold pulse on every channel.
module debounce_multi #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int HOLD_LIMIT     = 25000000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Hold
);

    localparam int DB_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic            sync_meta_r;
        logic            sync_r;
        logic            state_r;
        logic            state_next_s;
        logic [DB_W-1:0] db_cnt_r;
        logic [DB_W-1:0] db_cnt_next_s;
        logic            rise_r;
        logic            fall_r;
        logic            hold_r;
        logic            rise_next_s;
        logic            fall_next_s;
        logic            hold_event_s;

        // Two-flop synchroniser for the raw asynchronous switch level
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                sync_meta_r <= 1'b0;
                sync_r      <= 1'b0;
            end else begin
                sync_meta_r <= i_Switch[ch];
                sync_r      <= sync_meta_r;
            end
        end

        // Debounced state, qualification counter and registered event pulses
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                state_r  <= 1'b0;
                db_cnt_r <= '0;
                rise_r   <= 1'b0;
                fall_r   <= 1'b0;
                hold_r   <= 1'b0;
            end else begin
                state_r  <= state_next_s;
                db_cnt_r <= db_cnt_next_s;
                rise_r   <= rise_next_s;
                fall_r   <= fall_next_s;
                hold_r   <= hold_event_s;
            end
        end

        // Any return to the current level throws away all qualification progress
        always_comb begin
            state_next_s  = state_r;
            db_cnt_next_s = '0;
            if (sync_r == state_r) begin
                state_next_s  = state_r;
                db_cnt_next_s = '0;
            end else if (db_cnt_r == DB_LAST) begin
                state_next_s  = sync_r;
                db_cnt_next_s = '0;
            end else begin
                state_next_s  = state_r;
                db_cnt_next_s = db_cnt_r + DB_W'(1);
            end
        end

        // Edge events derived from the accepted level change
        always_comb begin
            rise_next_s = ~state_r & state_next_s;
            fall_next_s = state_r & ~state_next_s;
        end

        if (HOLD_LIMIT > 0) begin : g_hold
            localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_LIMIT);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

            logic [HOLD_W-1:0] hold_cnt_r;
            logic [HOLD_W-1:0] hold_cnt_next_s;

            // Hold duration counter, saturating so the pulse fires once per press
            always_ff @(posedge i_Clk) begin
                if (i_Reset) begin
                    hold_cnt_r <= '0;
                end else begin
                    hold_cnt_r <= hold_cnt_next_s;
                end
            end

            // A release qualifying on the firing cycle suppresses the hold pulse
            always_comb begin
                hold_cnt_next_s = hold_cnt_r;
                if (state_r == 1'b0) begin
                    hold_cnt_next_s = '0;
                end else if (hold_cnt_r != HOLD_MAX) begin
                    hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
                end else begin
                    hold_cnt_next_s = hold_cnt_r;
                end
                hold_event_s = state_r & state_next_s & (hold_cnt_r == HOLD_LAST);
            end
        end else begin : g_no_hold
            assign hold_event_s = 1'b0;
        end

        assign o_Switch[ch] = state_r;
        assign o_Rise[ch]   = rise_r;
        assign o_Fall[ch]   = fall_r;
        assign o_Hold[ch]   = hold_r;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: three parameter sets driven by one directed + random stimulus
// stream, each compared every cycle against a window-based behavioural model.
module tb_debounce_multi;

    logic       clk;
    logic       i_Reset;
    logic [1:0] i_Switch;

    logic [1:0] a_sw, a_rise, a_fall, a_hold;
    logic [1:0] b_sw, b_rise, b_fall, b_hold;
    logic [1:0] c_sw, c_rise, c_fall, c_hold;

    debounce_multi #(.NUM_CH(2), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(10)) dut_a (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Switch(i_Switch),
        .o_Switch(a_sw), .o_Rise(a_rise), .o_Fall(a_fall), .o_Hold(a_hold));

    debounce_multi #(.NUM_CH(2), .DEBOUNCE_LIMIT(1), .HOLD_LIMIT(10)) dut_b (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Switch(i_Switch),
        .o_Switch(b_sw), .o_Rise(b_rise), .o_Fall(b_fall), .o_Hold(b_hold));

    debounce_multi #(.NUM_CH(2), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(0)) dut_c (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Switch(i_Switch),
        .o_Switch(c_sw), .o_Rise(c_rise), .o_Fall(c_fall), .o_Hold(c_hold));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [1:0] act_sw[3], act_rise[3], act_fall[3], act_hold[3];
    assign act_sw[0] = a_sw;  assign act_rise[0] = a_rise;  assign act_fall[0] = a_fall;  assign act_hold[0] = a_hold;
    assign act_sw[1] = b_sw;  assign act_rise[1] = b_rise;  assign act_fall[1] = b_fall;  assign act_hold[1] = b_hold;
    assign act_sw[2] = c_sw;  assign act_rise[2] = c_rise;  assign act_fall[2] = c_fall;  assign act_hold[2] = c_hold;

    int lim_db[3]   = '{4, 1, 4};
    int lim_hold[3] = '{10, 10, 0};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: raw sample per edge, last reset edge, level and rise edge per channel
    logic [1:0] hist[0:4095];
    int         edge_n   = 0;
    int         last_rst = 0;
    bit         st[3][2];
    int         rise_e[3][2];
    logic [1:0] e_sw[3], e_rise[3], e_fall[3], e_hold[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // A channel flips when the synchronised value at each of the last L edges (all after
    // reset) differs from its level; the synchronised value at edge e is the raw sample of
    // edge e-2, or 0 if a reset happened at or after that edge.
    task automatic model_edge(input logic [1:0] sw, input logic rst);
        bit flip;
        bit s;
        int e;
        edge_n++;
        hist[edge_n] = sw;
        if (rst) last_rst = edge_n;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (rst) begin
                    st[k][c]     = 1'b0;
                    rise_e[k][c] = -1000000;
                    e_rise[k][c] = 1'b0;
                    e_fall[k][c] = 1'b0;
                    e_hold[k][c] = 1'b0;
                end else begin
                    flip = 1'b1;
                    for (int j = 0; j < lim_db[k]; j++) begin
                        e = edge_n - j;
                        if (e <= last_rst) begin
                            flip = 1'b0;
                        end else begin
                            s = (e - 2 > last_rst) ? hist[e-2][c] : 1'b0;
                            if (s == st[k][c]) flip = 1'b0;
                        end
                    end
                    e_rise[k][c] = flip && !st[k][c];
                    e_fall[k][c] = flip && st[k][c];
                    e_hold[k][c] = (lim_hold[k] > 0) && st[k][c] && !flip &&
                                   (edge_n - rise_e[k][c] == lim_hold[k]);
                    if (flip) begin
                        st[k][c] = !st[k][c];
                        if (st[k][c]) rise_e[k][c] = edge_n;
                    end
                end
                e_sw[k][c] = st[k][c];
            end
        end
    endtask

    task automatic step(input logic [1:0] sw, input logic rst);
        i_Switch = sw;
        i_Reset  = rst;
        @(posedge clk);
        model_edge(sw, rst);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("sw%0d", k),   {30'd0, act_sw[k]},   {30'd0, e_sw[k]});
            check_eq($sformatf("rise%0d", k), {30'd0, act_rise[k]}, {30'd0, e_rise[k]});
            check_eq($sformatf("fall%0d", k), {30'd0, act_fall[k]}, {30'd0, e_fall[k]});
            check_eq($sformatf("hold%0d", k), {30'd0, act_hold[k]}, {30'd0, e_hold[k]});
        end
    endtask

    initial begin
        int         a_first;
        int         b_first;
        int         cnt;
        int         cd[2];
        logic [1:0] cur;

        i_Switch = 2'b00;
        i_Reset  = 1'b1;
        #2;
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        check_eq("reset_out", {24'd0, a_sw, a_rise, a_fall, a_hold}, 32'd0);

        // Clean step on ch0: latency 2 + DEBOUNCE_LIMIT edges
        a_first = 0;
        b_first = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, 1'b0);
            if (a_first == 0 && a_rise[0]) a_first = k;
            if (b_first == 0 && b_rise[0]) b_first = k;
        end
        check_eq("lat_step_a", a_first, 32'd6);
        check_eq("lat_step_b", b_first, 32'd3);

        // Bounce on ch0 after returning low
        for (int k = 0; k < 10; k++) step(2'b00, 1'b0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin step(2'b01, 1'b0); cnt += int'(a_rise[0]); end
        step(2'b00, 1'b0);
        cnt += int'(a_rise[0]);
        a_first = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, 1'b0);
            cnt += int'(a_rise[0]);
            if (a_first == 0 && a_rise[0]) a_first = k;
        end
        check_eq("bounce_lat", a_first, 32'd6);
        check_eq("bounce_cnt", cnt, 32'd1);
        for (int k = 0; k < 10; k++) step(2'b00, 1'b0);

        // Long presses on ch1: one hold pulse per press
        cnt = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 26; k++) begin step(2'b10, 1'b0); cnt += int'(a_hold[1]); end
            a_first = 0;
            for (int k = 1; k <= 15; k++) begin
                step(2'b00, 1'b0);
                cnt += int'(a_hold[1]);
                if (a_first == 0 && a_fall[1]) a_first = k;
            end
            check_eq("fall_lat", a_first, 32'd6);
        end
        check_eq("hold_cnt", cnt, 32'd2);

        // Short press on ch0: no hold
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(2'b01, 1'b0); cnt += int'(a_hold[0]); end
        for (int k = 0; k < 15; k++) begin step(2'b00, 1'b0); cnt += int'(a_hold[0]); end
        check_eq("short_hold", cnt, 32'd0);

        // Reset in the middle of qualification with the input still high
        for (int k = 0; k < 4; k++) step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        check_eq("mid_rst_out", {24'd0, a_sw, a_rise, a_fall, a_hold}, 32'd0);
        a_first = 0;
        cnt     = 0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, 1'b0);
            cnt += int'(a_fall[0]);
            if (a_first == 0 && a_rise[0]) a_first = k;
        end
        check_eq("rst_rise_lat", a_first, 32'd6);
        check_eq("rst_no_fall", cnt, 32'd0);
        for (int k = 0; k < 10; k++) step(2'b00, 1'b0);

        // Fast toggling on ch0 (DEBOUNCE_LIMIT=1 instance follows it)
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step({1'b0, 1'(((k / 2) % 2) == 0)}, 1'b0);
            cnt += int'(b_rise[0]) + int'(b_fall[0]);
        end
        check_eq("toggle_edges", cnt, 32'd11);

        // Randomised segments of short bounces and long holds, with rare resets
        cur   = 2'b00;
        cd[0] = 0;
        cd[1] = 3;
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (cd[c] == 0) begin
                    cur[c] = ~cur[c];
                    cd[c]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(5, 30));
                end else begin
                    cd[c]--;
                end
            end
            step(cur, 1'($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
